// File: rtl/half_adder_pkg.sv
// Shared arithmetic constants for the adder/ALU datapath blocks.
package half_adder_pkg;

  // Default width of carry event counters reused across datapath blocks.
  localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/half_adder_slice.sv
// Single-bit half-adder cell: xor for sum, and for carry.
module half_adder_slice (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// Bit-sliced half adder with a combinational result, a one-cycle registered
// copy of it, and a saturating count of accepted operands that carried.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  logic [WIDTH-1:0] sum_q_reg;
  logic [WIDTH-1:0] carry_q_reg;
  logic             out_valid_reg;
  logic [CNT_W-1:0] carry_cnt_reg;
  logic [CNT_W-1:0] carry_cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_slice
      half_adder_slice u_slice (
        .a     (a[gi]),
        .b     (b[gi]),
        .sum   (sum[gi]),
        .carry (carry[gi])
      );
    end
  endgenerate

  // Count stops at all-ones rather than wrapping.
  always_comb begin
    carry_cnt_next = carry_cnt_reg;
    if (in_valid && (|carry) && (carry_cnt_reg != {CNT_W{1'b1}}))
      carry_cnt_next = carry_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q_reg     <= '0;
      carry_q_reg   <= '0;
      out_valid_reg <= 1'b0;
      carry_cnt_reg <= '0;
    end else begin
      out_valid_reg <= in_valid;
      carry_cnt_reg <= carry_cnt_next;
      if (in_valid) begin
        sum_q_reg   <= sum;
        carry_q_reg <= carry;
      end
    end
  end

  assign sum_q     = sum_q_reg;
  assign carry_q   = carry_q_reg;
  assign out_valid = out_valid_reg;
  assign carry_cnt = carry_cnt_reg;

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: one-bit instance with a 2-bit counter and a four-bit instance.
module tb_half_adder;

  typedef struct {
    logic [3:0] s;
    logic [3:0] c;
    logic [7:0] n;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic       a1, b1, iv1;
  logic       sum1, carry1, sum_q1, carry_q1, ov1;
  logic [1:0] cnt1;

  logic [3:0] a4, b4;
  logic       iv4;
  logic [3:0] sum4, carry4, sum_q4, carry_q4;
  logic       ov4;
  logic [7:0] cnt4;

  exp_t q1[$];
  exp_t q4[$];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .CNT_W(2)) dut1 (
    .sum(sum1), .carry(carry1), .a(a1), .b(b1), .clk(clk), .rst(rst),
    .in_valid(iv1), .sum_q(sum_q1), .carry_q(carry_q1), .out_valid(ov1),
    .carry_cnt(cnt1)
  );

  half_adder #(.WIDTH(4), .CNT_W(8)) dut4 (
    .sum(sum4), .carry(carry4), .a(a4), .b(b4), .clk(clk), .rst(rst),
    .in_valid(iv4), .sum_q(sum_q4), .carry_q(carry_q4), .out_valid(ov4),
    .carry_cnt(cnt4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Scoreboard monitors: pop one expectation per presented result.
  always @(negedge clk) begin
    if (ov1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("w1_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("w1_sum_q", {31'd0, sum_q1}, {31'd0, e.s[0]});
        chk("w1_carry_q", {31'd0, carry_q1}, {31'd0, e.c[0]});
        chk("w1_cnt", {30'd0, cnt1}, {24'd0, e.n});
      end
    end
  end

  always @(negedge clk) begin
    if (ov4 === 1'b1) begin
      if (q4.size() == 0) begin
        chk("w4_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("w4_sum_q", {28'd0, sum_q4}, {28'd0, e.s});
        chk("w4_carry_q", {28'd0, carry_q4}, {28'd0, e.c});
        chk("w4_cnt", {24'd0, cnt4}, {24'd0, e.n});
      end
    end
  end

  task automatic set1(input logic v, input logic aa, input logic bb,
                      input logic es, input logic ec, input logic [7:0] en);
    @(negedge clk);
    rst = 1'b0; iv1 = v; a1 = aa; b1 = bb;
    if (v) q1.push_back('{s: {3'd0, es}, c: {3'd0, ec}, n: en});
  endtask

  task automatic set4(input logic v, input logic [3:0] aa, input logic [3:0] bb,
                      input logic [3:0] es, input logic [3:0] ec, input logic [7:0] en);
    @(negedge clk);
    rst = 1'b0; iv4 = v; a4 = aa; b4 = bb;
    if (v) q4.push_back('{s: es, c: ec, n: en});
  endtask

  logic [1:0] tt_exp [4];

  initial begin
    rst = 1'b1; iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    iv4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    // {sum, carry} for ab = 00, 01, 10, 11
    tt_exp[0] = 2'b00; tt_exp[1] = 2'b10; tt_exp[2] = 2'b10; tt_exp[3] = 2'b01;

    // Combinational truth table, held in reset to show reset has no effect.
    for (int i = 0; i < 4; i++) begin
      a1 = i[1]; b1 = i[0];
      #5;
      chk($sformatf("comb_tt_%0d", i), {30'd0, sum1, carry1}, {30'd0, tt_exp[i]});
    end
    a4 = 4'b1010; b4 = 4'b0110; #5;
    chk("comb4_sum_a", {28'd0, sum4}, 32'b1100);
    chk("comb4_carry_a", {28'd0, carry4}, 32'b0010);
    a4 = 4'b0101; b4 = 4'b1010; #5;
    chk("comb4_sum_b", {28'd0, sum4}, 32'b1111);
    chk("comb4_carry_b", {28'd0, carry4}, 32'b0000);

    // Reset coinciding with valid carrying inputs: input is dropped.
    @(negedge clk);
    rst = 1'b1; iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    @(negedge clk);
    chk("rst_w1_regs", {26'd0, sum_q1, carry_q1, ov1, 1'b0, cnt1}, 32'd0);
    chk("rst_w4_sum_carry", {24'd0, sum_q4, carry_q4}, 32'd0);
    chk("rst_w4_ov_cnt", {23'd0, ov4, cnt4}, 32'd0);
    iv4 = 1'b0;

    // Registered latency then hold on an idle edge.
    set1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
    set1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    chk("idle_out_valid", {31'd0, ov1}, 32'd0);
    chk("idle_hold_sum_q", {31'd0, sum_q1}, 32'd0);
    chk("idle_hold_carry_q", {31'd0, carry_q1}, 32'd1);
    chk("idle_hold_cnt", {30'd0, cnt1}, 32'd1);

    // Back-to-back carries drive the 2-bit counter into saturation.
    set1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2);
    set1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3);
    set1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3);
    set1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3);
    set1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3);
    set1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
    set1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3);

    // Mid-stream reset with valid asserted clears everything.
    @(negedge clk);
    rst = 1'b1; iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    chk("midrst_cnt", {30'd0, cnt1}, 32'd0);
    chk("midrst_regs", {29'd0, sum_q1, carry_q1, ov1}, 32'd0);
    set1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    set1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1);
    set1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Multi-bit registered path; a no-carry operand must not count.
    set4(1'b1, 4'b1010, 4'b0110, 4'b1100, 4'b0010, 8'd1);
    set4(1'b1, 4'b0101, 4'b1010, 4'b1111, 4'b0000, 8'd1);
    set4(1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b1111, 8'd2);
    set4(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0);
    @(negedge clk);
    @(negedge clk);
    chk("w4_final_cnt", {24'd0, cnt4}, 32'd2);
    chk("w4_final_hold_carry", {28'd0, carry_q4}, 32'b1111);
    chk("w1_queue_drained", q1.size(), 32'd0);
    chk("w4_queue_drained", q4.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
